up2_timer_ctrl: RTL and testbench
=================================

Name: up2_timer_ctrl

Overview:
Synchronous controller that sequences the up2_timer digit chain (cascaded up/down digit counters driven by rising edges on active-low INC/DEC strobes). It divides CLK into a 1-second tick and runs the chain up or down. It accepts manual set/reset buttons, stops on terminal count, and raises an alarm. It is the only driver of the chain's INC, DEC and CLR lines.

Parameters:
TICK_DIV, 50000000, CLK cycles per count tick; must be >= 4*PULSE_W
PULSE_W, 2, cycles INC/DEC/CNT_CLR are held low per strobe; also the minimum high guard after each strobe; must be >= 2

Ports:
CLK  input  1  system clock, all state on rising edge
CLR  input  1  asynchronous active-low reset
BTN_START  input  1  one-cycle sync pulse: start/pause/resume/acknowledge alarm
BTN_RST  input  1  one-cycle sync pulse: clear the chain and return to IDLE
BTN_UP  input  1  one-cycle sync pulse: manual +1 (IDLE/PAUSE only)
BTN_DOWN  input  1  one-cycle sync pulse: manual -1 (IDLE/PAUSE only)
DIR  input  1  1 = count down, 0 = count up; sampled on start from IDLE
ZERO  input  1  async from chain, all digits 0
FULL  input  1  async from chain, all digits at maximum
INC  output  1  chain increment strobe, idle high, action on rising edge
DEC  output  1  chain decrement strobe, idle high, action on rising edge
CNT_CLR  output  1  chain clear, active low
RUNNING  output  1  high in RUN
ALARM  output  1  high in ALM
BUSY  output  1  strobe or guard in progress

Behaviour:
- Reset (CLR low, async): state=IDLE; INC=1, DEC=1, CNT_CLR=0, RUNNING=0, ALARM=0, BUSY=0; prescaler=0; dir_q=0; synchronisers=0. On the first CLK edge after release, CNT_CLR=1.
- ZERO and FULL pass through 2-flop synchronisers (ZERO_s, FULL_s). All decisions use the synchronised values.
- Strobe engine: on a request, drive the selected line low for exactly PULSE_W cycles, then hold it high for PULSE_W guard cycles. BUSY is high across both phases.
  - INC and DEC are never low simultaneously. The non-selected line stays high throughout, which is the chain's requirement.
  - Manual requests arriving while BUSY are dropped, not queued.
- States: IDLE, RUN, PAUSE, ALM.
  - IDLE, BTN_START: if DIR=1 and ZERO_s=1, ignore. Otherwise latch dir_q=DIR, clear the prescaler, go to RUN.
  - RUN: the prescaler counts 0..TICK_DIV-1. At terminal count it issues a tick and wraps to 0.
    - Tick with dir_q=1: if ZERO_s, go to ALM with no strobe; else issue a DEC strobe.
    - Tick with dir_q=0: if FULL_s, go to ALM with no strobe; else issue an INC strobe.
    - BTN_START goes to PAUSE. The prescaler value is held, and any strobe already in flight completes.
  - PAUSE: BTN_START returns to RUN and resumes the prescaler from its held value.
  - ALM: ALARM=1. BTN_START or BTN_RST goes to IDLE; the BTN_RST case also issues the clear sequence.
- Manual set (IDLE or PAUSE only, BUSY=0):
  - BTN_UP issues an INC strobe unless FULL_s.
  - BTN_DOWN issues a DEC strobe unless ZERO_s.
  - Both in the same cycle: ignore both.
  - Ignored in RUN and ALM.
- BTN_RST, in any state: abort any strobe (INC=DEC=1 immediately). Then CNT_CLR=0 for PULSE_W cycles followed by a PULSE_W guard with BUSY=1. State goes to IDLE, prescaler=0.
- Priority when buttons coincide: BTN_RST > BTN_START > BTN_UP/BTN_DOWN. A tick coinciding with BTN_START in RUN: the pause wins and the tick is discarded; the prescaler holds at TICK_DIV-1.
- Latency: the strobe's falling edge occurs 1 cycle after the tick/button cycle. The chain updates at the rising edge, PULSE_W cycles later. ZERO_s/FULL_s reflect it 2 cycles after that, which is before the guard ends.

Test Plan:
- Reset: hold CLR low mid-strobe -> INC=DEC=1, CNT_CLR=0, state IDLE; after release, CNT_CLR=1 on the next edge.
- Up run: TICK_DIV=8, PULSE_W=2, DIR=0, BTN_START -> INC low for exactly 2 cycles every 8 cycles; DEC constantly 1; RUNNING=1.
- Down to zero: chain model preset to 3, DIR=1, start -> exactly 3 DEC strobes; at the 4th tick, ALARM=1 with no strobe. BTN_START -> IDLE, ALARM=0.
- Pause: pause at prescaler=5, wait 20 cycles, resume -> next tick 3 cycles after resume; no strobes while paused.
- Manual set: in IDLE, BTN_UP, then BTN_UP 1 cycle later -> one INC strobe (second dropped, BUSY). BTN_UP+BTN_DOWN together -> nothing. BTN_DOWN with ZERO=1 -> nothing.
- Reset button: BTN_RST during an INC low phase -> INC rises next cycle; CNT_CLR low for 2 cycles; state IDLE; BTN_START with DIR=1 and ZERO=1 stays IDLE.

Source files
------------

// File: rtl/up2_timer_ctrl_if.sv
// up2_timer_ctrl_if: button, direction, chain status and chain strobe signals
// between the timer controller and the up2_timer digit chain / user side.
//   master: drives the buttons, DIR and the chain status (ZERO/FULL), and
//           observes the strobes and status flags.
//   slave : the controller; consumes the buttons and status, and drives
//           INC/DEC/CNT_CLR plus RUNNING/ALARM/BUSY.
interface up2_timer_ctrl_if;
    logic BTN_START;
    logic BTN_RST;
    logic BTN_UP;
    logic BTN_DOWN;
    logic DIR;
    logic ZERO;
    logic FULL;
    logic INC;
    logic DEC;
    logic CNT_CLR;
    logic RUNNING;
    logic ALARM;
    logic BUSY;

    modport master (
        output BTN_START, BTN_RST, BTN_UP, BTN_DOWN, DIR, ZERO, FULL,
        input  INC, DEC, CNT_CLR, RUNNING, ALARM, BUSY
    );

    modport slave (
        input  BTN_START, BTN_RST, BTN_UP, BTN_DOWN, DIR, ZERO, FULL,
        output INC, DEC, CNT_CLR, RUNNING, ALARM, BUSY
    );
endinterface

// File: rtl/up2_timer_ctrl.sv
// up2_timer_ctrl: sequences the up2_timer digit chain. Divides CLK into a
// count tick, runs the chain up or down, handles manual set/clear buttons,
// stops on terminal count and raises ALARM. Sole driver of INC/DEC/CNT_CLR.
//   CLK  : system clock, all state on the rising edge
//   CLR  : asynchronous active-low reset
//   bus  : slave side of up2_timer_ctrl_if (buttons, DIR, ZERO/FULL in;
//          INC/DEC/CNT_CLR strobes and RUNNING/ALARM/BUSY flags out)
module up2_timer_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned PULSE_W  = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    up2_timer_ctrl_if.slave  bus
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PC_W  = (PULSE_W  > 1) ? $clog2(PULSE_W)  : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0]  PC_TOP  = PC_W'(PULSE_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALM} state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_GUARD} phase_t;

    state_t           state;
    phase_t           phase;
    logic [PRE_W-1:0] pre;
    logic [PC_W-1:0]  pcnt;
    logic             dir_q;
    logic             zero_m, zero_s;
    logic             full_m, full_s;
    logic             inc, dec, cnt_clr;
    logic             running, alarm, busy;

    // Manual requests: exactly one of UP/DOWN, and not against a terminal.
    logic up_ok, down_ok;
    always_comb begin
        up_ok   = bus.BTN_UP   && !bus.BTN_DOWN && !full_s;
        down_ok = bus.BTN_DOWN && !bus.BTN_UP   && !zero_s;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= IDLE;
            phase   <= PH_IDLE;
            pre     <= '0;
            pcnt    <= '0;
            dir_q   <= 1'b0;
            zero_m  <= 1'b0;
            zero_s  <= 1'b0;
            full_m  <= 1'b0;
            full_s  <= 1'b0;
            inc     <= 1'b1;
            dec     <= 1'b1;
            cnt_clr <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            zero_m <= bus.ZERO;
            zero_s <= zero_m;
            full_m <= bus.FULL;
            full_s <= full_m;

            // Strobe engine: low phase, then guard phase, BUSY across both.
            // The FSM below may override these assignments when it starts a
            // new strobe (only when idle) or aborts for BTN_RST.
            case (phase)
                PH_IDLE: cnt_clr <= 1'b1;
                PH_LOW: begin
                    if (pcnt == PC_TOP) begin
                        phase   <= PH_GUARD;
                        pcnt    <= '0;
                        inc     <= 1'b1;
                        dec     <= 1'b1;
                        cnt_clr <= 1'b1;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                PH_GUARD: begin
                    if (pcnt == PC_TOP) begin
                        phase <= PH_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase

            if (bus.BTN_RST) begin
                // Abort whatever is in flight and start the clear sequence.
                inc     <= 1'b1;
                dec     <= 1'b1;
                cnt_clr <= 1'b0;
                phase   <= PH_LOW;
                pcnt    <= '0;
                busy    <= 1'b1;
                state   <= IDLE;
                running <= 1'b0;
                alarm   <= 1'b0;
                pre     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.BTN_START) begin
                            if (!(bus.DIR && zero_s)) begin
                                dir_q   <= bus.DIR;
                                pre     <= '0;
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end else if (!busy && (up_ok || down_ok)) begin
                            inc   <= !up_ok;
                            dec   <= !down_ok;
                            phase <= PH_LOW;
                            pcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.BTN_START) begin
                            // Pause wins over a coincident tick; prescaler holds.
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (pre == PRE_TOP) begin
                            pre <= '0;
                            if (dir_q ? zero_s : full_s) begin
                                state   <= ALM;
                                running <= 1'b0;
                                alarm   <= 1'b1;
                            end else if (!busy) begin
                                inc   <= dir_q;
                                dec   <= !dir_q;
                                phase <= PH_LOW;
                                pcnt  <= '0;
                                busy  <= 1'b1;
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (bus.BTN_START) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (!busy && (up_ok || down_ok)) begin
                            inc   <= !up_ok;
                            dec   <= !down_ok;
                            phase <= PH_LOW;
                            pcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ALM: begin
                        if (bus.BTN_START) begin
                            state <= IDLE;
                            alarm <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.INC     = inc;
    assign bus.DEC     = dec;
    assign bus.CNT_CLR = cnt_clr;
    assign bus.RUNNING = running;
    assign bus.ALARM   = alarm;
    assign bus.BUSY    = busy;

endmodule

// File: tb/tb_up2_timer_ctrl.sv
// tb_up2_timer_ctrl: directed bench for up2_timer_ctrl with TICK_DIV=8,
// PULSE_W=2 and a small single-digit chain model (0..9) driving ZERO/FULL.
module tb_up2_timer_ctrl;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    up2_timer_ctrl_if bus();

    up2_timer_ctrl #(.TICK_DIV(8), .PULSE_W(2)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Chain model: counts on rising INC/DEC, cleared while CNT_CLR is low.
    int   chain_val  = 0;
    int   preset_val = 0;
    logic preset_req = 1'b0;
    logic prev_inc   = 1'b1;
    logic prev_dec   = 1'b1;

    always @(posedge CLK) begin
        if (preset_req)                   chain_val <= preset_val;
        else if (!bus.CNT_CLR)            chain_val <= 0;
        else if (bus.INC && !prev_inc)    chain_val <= chain_val + 1;
        else if (bus.DEC && !prev_dec)    chain_val <= chain_val - 1;
        prev_inc <= bus.INC;
        prev_dec <= bus.DEC;
    end

    assign bus.ZERO = (chain_val == 0);
    assign bus.FULL = (chain_val == 9);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic pulse(input logic s, input logic r, input logic u, input logic d);
        bus.BTN_START = s;
        bus.BTN_RST   = r;
        bus.BTN_UP    = u;
        bus.BTN_DOWN  = d;
        step();
        bus.BTN_START = 1'b0;
        bus.BTN_RST   = 1'b0;
        bus.BTN_UP    = 1'b0;
        bus.BTN_DOWN  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_l;
        int   strobes;
        logic last_dec;

        bus.BTN_START = 1'b0;
        bus.BTN_RST   = 1'b0;
        bus.BTN_UP    = 1'b0;
        bus.BTN_DOWN  = 1'b0;
        bus.DIR       = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_inc",     bus.INC,     1);
        chk("rst_dec",     bus.DEC,     1);
        chk("rst_cnt_clr", bus.CNT_CLR, 0);
        chk("rst_running", bus.RUNNING, 0);
        chk("rst_alarm",   bus.ALARM,   0);
        chk("rst_busy",    bus.BUSY,    0);
        CLR = 1'b1;
        step();
        chk("rel_cnt_clr", bus.CNT_CLR, 1);
        repeat (3) step();

        // Manual set: second UP one cycle later is dropped
        pulse(0, 0, 1, 0);
        chk("up1_inc_low",  bus.INC,  0);
        chk("up1_busy",     bus.BUSY, 1);
        pulse(0, 0, 1, 0);
        chk("up2_inc_low",  bus.INC,  0);
        step();
        chk("up_guard_inc", bus.INC,  1);
        chk("up_guard_bsy", bus.BUSY, 1);
        step();
        chk("up_guard_bsy2", bus.BUSY, 1);
        step();
        chk("up_done_busy", bus.BUSY, 0);
        chk("up_done_inc",  bus.INC,  1);
        repeat (3) step();

        // UP and DOWN together: ignored
        pulse(0, 0, 1, 1);
        chk("both_inc",  bus.INC,  1);
        chk("both_dec",  bus.DEC,  1);
        chk("both_busy", bus.BUSY, 0);
        step();
        chk("both_inc2", bus.INC,  1);

        // Valid DOWN brings chain 1 -> 0, then DOWN at zero is ignored
        pulse(0, 0, 0, 1);
        chk("down_dec_low", bus.DEC, 0);
        chk("down_inc",     bus.INC, 1);
        repeat (8) step();
        pulse(0, 0, 0, 1);
        chk("down0_dec",  bus.DEC,  1);
        chk("down0_busy", bus.BUSY, 0);

        // Up run: INC low for 2 cycles every 8 cycles
        repeat (2) step();
        bus.DIR = 1'b0;
        pulse(1, 0, 0, 0);
        chk("run_running", bus.RUNNING, 1);
        for (int k = 1; k <= 29; k++) begin
            step();
            exp_l = (k >= 8 && ((k % 8) == 0 || (k % 8) == 1)) ? 1'b0 : 1'b1;
            chk($sformatf("uprun_inc_k%0d", k), bus.INC, exp_l);
            chk($sformatf("uprun_dec_k%0d", k), bus.DEC, 1);
        end

        // Pause at prescaler=5, no strobes while paused, tick 3 cycles after resume
        pulse(1, 0, 0, 0);
        chk("pause_running", bus.RUNNING, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("pause_inc_%0d", k), bus.INC, 1);
        end
        pulse(1, 0, 0, 0);
        chk("resume_running", bus.RUNNING, 1);
        step();
        chk("resume_r1_inc", bus.INC, 1);
        step();
        chk("resume_r2_inc", bus.INC, 1);
        step();
        chk("resume_r3_inc", bus.INC, 0);

        // BTN_RST during INC low phase
        pulse(0, 1, 0, 0);
        chk("brst_inc",     bus.INC,     1);
        chk("brst_cnt_clr", bus.CNT_CLR, 0);
        chk("brst_busy",    bus.BUSY,    1);
        chk("brst_running", bus.RUNNING, 0);
        step();
        chk("brst_cnt_clr2", bus.CNT_CLR, 0);
        step();
        chk("brst_cnt_clr3", bus.CNT_CLR, 1);
        chk("brst_guard",    bus.BUSY,    1);
        repeat (2) step();
        chk("brst_done",     bus.BUSY,    0);

        // START with DIR=1 at zero stays in IDLE
        bus.DIR = 1'b1;
        repeat (2) step();
        pulse(1, 0, 0, 0);
        chk("dz_running", bus.RUNNING, 0);
        repeat (9) step();
        chk("dz_running2", bus.RUNNING, 0);
        chk("dz_dec",      bus.DEC,     1);

        // Down to zero from 3: three DEC strobes, alarm on the 4th tick
        preset_val = 3;
        preset_req = 1'b1;
        step();
        preset_req = 1'b0;
        repeat (4) step();
        pulse(1, 0, 0, 0);
        chk("down_running", bus.RUNNING, 1);
        strobes  = 0;
        last_dec = bus.DEC;
        for (int k = 1; k <= 33; k++) begin
            step();
            exp_l = (k == 8 || k == 9 || k == 16 || k == 17 || k == 24 || k == 25) ? 1'b0 : 1'b1;
            chk($sformatf("dn_dec_k%0d", k),   bus.DEC,   exp_l);
            chk($sformatf("dn_alarm_k%0d", k), bus.ALARM, (k >= 32) ? 1'b1 : 1'b0);
            if (last_dec && !bus.DEC) strobes++;
            last_dec = bus.DEC;
        end
        chk("dn_strobes",   strobes,     3);
        chk("alm_running",  bus.RUNNING, 0);
        pulse(1, 0, 0, 0);
        chk("ack_alarm",    bus.ALARM,   0);
        chk("ack_running",  bus.RUNNING, 0);

        // Async reset held mid-strobe
        repeat (2) step();
        pulse(0, 0, 1, 0);
        chk("ar_inc_low", bus.INC, 0);
        CLR = 1'b0;
        #1;
        chk("ar_inc",     bus.INC,     1);
        chk("ar_dec",     bus.DEC,     1);
        chk("ar_cnt_clr", bus.CNT_CLR, 0);
        chk("ar_busy",    bus.BUSY,    0);
        step();
        step();
        chk("ar_hold_cnt_clr", bus.CNT_CLR, 0);
        CLR = 1'b1;
        step();
        chk("ar_rel_cnt_clr", bus.CNT_CLR, 1);
        chk("ar_rel_running", bus.RUNNING, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
